// File: rtl/upgrade_pkg.sv
// Shared types and screen constants for the upgrade pickup path (spawner, collector, sprite ROM).
package upgrade_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    PLACE  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [9:0]  SCREEN_W  = 10'd640;
  localparam logic [9:0]  SCREEN_H  = 10'd480;

  // Largest 2^k-1 not exceeding span; keeps a forced draw inside the legal window.
  function automatic logic [9:0] fold_mask(input logic [9:0] span);
    logic [9:0] m;
    m = span | (span >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return (m > span) ? (m >> 1) : m;
  endfunction

endpackage

// File: rtl/upgrade_lfsr.sv
// 16-bit Galois LFSR, right-shifting with feedback mask LFSR_MASK; advances on i_step.
module upgrade_lfsr
  import upgrade_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_step,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_step) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/upgrade_spawner.sv
// Places one upgrade pickup at an LFSR-chosen position after a delay and retires it on collection or timeout.
// Optional UPGRADE_BLINK_EN: sprite blinks (cnt[3]) during the last 64 live frames.
module upgrade_spawner
  import upgrade_pkg::*;
#(
  parameter logic [9:0]  X_MIN       = 10'd32,
  parameter logic [9:0]  X_MAX       = 10'd607,
  parameter logic [9:0]  Y_MIN       = 10'd32,
  parameter logic [9:0]  Y_MAX       = 10'd447,
  parameter logic [9:0]  PARK_X      = 10'd700,
  parameter logic [9:0]  PARK_Y      = 10'd600,
  parameter logic [9:0]  UPG_SIZE    = 10'd6,
  parameter int          SPAWN_DELAY = 300,
  parameter int          LIFETIME    = 600,
  parameter int          MAX_REJECT  = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       was_collected,
  output logic [9:0] UpgradeX,
  output logic [9:0] UpgradeY,
  output logic [9:0] Upgrade_Size,
  output logic       upgrade_active,
  output logic       upgrade_visible,
  output logic       respawn
);

  localparam int CNT_MAX   = (SPAWN_DELAY > LIFETIME) ? SPAWN_DELAY : LIFETIME;
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W     = (CNT_W_RAW < 7) ? 7 : CNT_W_RAW;
  localparam int REJ_W     = $clog2(MAX_REJECT + 1);

  localparam logic [CNT_W-1:0] SD_LOAD  = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [CNT_W-1:0] LT_LOAD  = CNT_W'(LIFETIME - 1);
  localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(MAX_REJECT - 1);
  localparam logic [9:0]       SX       = X_MAX - X_MIN;
  localparam logic [9:0]       SY       = Y_MAX - Y_MIN;
  localparam logic [9:0]       FOLD_X   = fold_mask(SX);
  localparam logic [9:0]       FOLD_Y   = fold_mask(SY);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REJ_W-1:0] r_rej;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_active;
  logic             r_visible;
  logic             r_respawn;
  logic             r_first;

  logic [15:0]      w_lfsr;
  logic [9:0]       w_cx;
  logic [9:0]       w_cy;
  logic             w_fit;
  logic             w_last;
  logic [9:0]       w_cx_pick;
  logic [9:0]       w_cy_pick;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_vis_load;
  logic             w_vis_dec;
  logic             w_retire;

  upgrade_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk  (frame_clk),
    .i_rst  (Reset),
    .i_step (enable),
    .o_lfsr (w_lfsr)
  );

  assign w_cx      = w_lfsr[9:0];
  assign w_cy      = w_lfsr[15:6];
  assign w_fit     = (w_cx <= SX) && (w_cy <= SY);
  assign w_last    = (r_rej == REJ_LAST);
  assign w_cx_pick = w_fit ? w_cx : (w_cx & FOLD_X);
  assign w_cy_pick = w_fit ? w_cy : (w_cy & FOLD_Y);
  assign w_cnt_dec = r_cnt - CNT_W'(1);
  // The first live frame ignores the flag: the collector is still clearing its latch.
  assign w_retire  = (was_collected && !r_first) || (r_cnt == '0);

`ifdef UPGRADE_BLINK_EN
  assign w_vis_load = (LT_LOAD < CNT_W'(64)) ? LT_LOAD[3] : 1'b1;
  assign w_vis_dec  = (w_cnt_dec < CNT_W'(64)) ? w_cnt_dec[3] : 1'b1;
`else
  assign w_vis_load = 1'b1;
  assign w_vis_dec  = 1'b1;
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state   <= WAIT;
      r_cnt     <= SD_LOAD;
      r_rej     <= '0;
      r_x       <= PARK_X;
      r_y       <= PARK_Y;
      r_active  <= 1'b0;
      r_visible <= 1'b0;
      r_respawn <= 1'b0;
      r_first   <= 1'b0;
    end else if (!enable) begin
      r_respawn <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        WAIT: begin
          if (r_cnt == '0) r_state <= PLACE;
          else             r_cnt   <= w_cnt_dec;
        end
        PLACE: begin
          if (w_fit || w_last) begin
            r_state   <= ACTIVE;
            r_rej     <= '0;
            r_x       <= X_MIN + w_cx_pick;
            r_y       <= Y_MIN + w_cy_pick;
            r_cnt     <= LT_LOAD;
            r_active  <= 1'b1;
            r_visible <= w_vis_load;
            r_respawn <= 1'b1;
            r_first   <= 1'b1;
          end else begin
            r_rej <= r_rej + REJ_W'(1);
          end
        end
        ACTIVE: begin
          r_first <= 1'b0;
          if (w_retire) begin
            r_state   <= WAIT;
            r_cnt     <= SD_LOAD;
            r_x       <= PARK_X;
            r_y       <= PARK_Y;
            r_active  <= 1'b0;
            r_visible <= 1'b0;
          end else begin
            r_cnt     <= w_cnt_dec;
            r_visible <= w_vis_dec;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign UpgradeX        = r_x;
  assign UpgradeY        = r_y;
  assign Upgrade_Size    = UPG_SIZE;
  assign upgrade_active  = r_active;
  assign upgrade_visible = r_visible;
  assign respawn         = r_respawn;

endmodule

// File: tb/tb_upgrade_spawner.sv
// Scoreboard bench for upgrade_spawner: stimulus pushes expected spawn/despawn events, a monitor checks them.
module tb_upgrade_spawner;

  localparam logic [15:0] SEED = 16'h77FD;
  localparam int SD = 4;
  localparam int LT = 10;
  localparam int K_SPAWN = 0;
  localparam int K_DESP  = 1;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b1;
  logic       was_collected = 1'b0;
  logic [9:0] UpgradeX, UpgradeY, Upgrade_Size;
  logic       upgrade_active, upgrade_visible, respawn;

  always #5 frame_clk = ~frame_clk;

  upgrade_spawner #(
    .SPAWN_DELAY (SD),
    .LIFETIME    (LT),
    .LFSR_SEED   (SEED)
  ) dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .enable          (enable),
    .was_collected   (was_collected),
    .UpgradeX        (UpgradeX),
    .UpgradeY        (UpgradeY),
    .Upgrade_Size    (Upgrade_Size),
    .upgrade_active  (upgrade_active),
    .upgrade_visible (upgrade_visible),
    .respawn         (respawn)
  );

  typedef struct {
    int kind;
    int at;
    int x;
    int y;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ecnt    = 0;
  logic en_q    = 1'b1;
  logic rst_q   = 1'b1;

  // Enabled-edge index since reset release; edge 1 is the first enabled edge out of reset.
  always @(posedge frame_clk) begin
    if (Reset) ecnt <= 0;
    else if (enable) ecnt <= ecnt + 1;
    en_q  <= enable;
    rst_q <= Reset;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int at, input int x, input int y);
    exp_t e;
    e.kind = kind; e.at = at; e.x = x; e.y = y;
    q.push_back(e);
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] s;
    s = SEED;
    for (int i = 1; i < k; i++) s = step(s);
    return s;
  endfunction

  // Placement outcome for a PLACE phase whose first draw happens at enabled edge 'first'.
  task automatic predict(input int first, output int entry, output int x, output int y);
    logic [15:0] s;
    int cx, cy;
    bit done;
    s = lfsr_at(first);
    done = 0;
    entry = 0; x = 0; y = 0;
    for (int d = 0; d < 8; d++) begin
      if (!done) begin
        cx = int'(s[9:0]);
        cy = int'(s[15:6]);
        if ((cx <= 575 && cy <= 415) || d == 7) begin
          if (!(cx <= 575 && cy <= 415)) begin
            cx = cx % 512;
            cy = cy % 256;
          end
          entry = first + d;
          x = 32 + cx;
          y = 32 + cy;
          done = 1;
        end
        s = step(s);
      end
    end
  endtask

  task automatic wait_edge(input int k);
    int n;
    n = 0;
    while (ecnt < k && n < 500) begin
      @(negedge frame_clk);
      n++;
    end
    if (ecnt < k) chk("wait_timeout", ecnt, k);
  endtask

  initial begin : monitor
    logic       prev_act, prev_vis;
    logic [9:0] px, py;
    exp_t       e;
    prev_act = 1'b0; prev_vis = 1'b0; px = 10'd700; py = 10'd600;
    forever begin
      @(negedge frame_clk);
      if (!en_q && !rst_q) begin
        chk("freeze_x", int'(UpgradeX), int'(px));
        chk("freeze_y", int'(UpgradeY), int'(py));
        chk("freeze_act_vis", int'({upgrade_active, upgrade_visible}), int'({prev_act, prev_vis}));
        chk("freeze_respawn", int'(respawn), 0);
      end
`ifdef UPGRADE_BLINK_EN
      if (upgrade_visible && !upgrade_active) chk("vis_without_active", 1, 0);
`else
      chk("vis_eq_active", int'(upgrade_visible), int'(upgrade_active));
`endif
      if (respawn) begin
        if (q.size() == 0) chk("spawn_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("spawn_kind", K_SPAWN, e.kind);
          chk("spawn_edge", ecnt, e.at);
          chk("spawn_x", int'(UpgradeX), e.x);
          chk("spawn_y", int'(UpgradeY), e.y);
          chk("spawn_active", int'(upgrade_active), 1);
          chk("spawn_visible", int'(upgrade_visible), 1);
          chk("spawn_size", int'(Upgrade_Size), 6);
        end
      end
      if (prev_act && !upgrade_active) begin
        if (q.size() == 0) chk("despawn_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("desp_kind", K_DESP, e.kind);
          chk("desp_edge", ecnt, e.at);
          chk("desp_x", int'(UpgradeX), 700);
          chk("desp_y", int'(UpgradeY), 600);
          chk("desp_visible", int'(upgrade_visible), 0);
          chk("desp_respawn", int'(respawn), 0);
        end
      end
      prev_act = upgrade_active;
      prev_vis = upgrade_visible;
      px = UpgradeX;
      py = UpgradeY;
    end
  end

  initial begin : stimulus
    int ec, ed, x, y;
    Reset = 1'b1; enable = 1'b1; was_collected = 1'b0;
    repeat (3) @(posedge frame_clk);
    @(negedge frame_clk);
    chk("rst_x", int'(UpgradeX), 700);
    chk("rst_y", int'(UpgradeY), 600);
    chk("rst_active", int'(upgrade_active), 0);
    chk("rst_visible", int'(upgrade_visible), 0);
    chk("rst_respawn", int'(respawn), 0);
    chk("rst_size", int'(Upgrade_Size), 6);

    // Draws at edges 5..12 all out of range (FFFF..D84F); the 8th is folded to (79,97).
    push(K_SPAWN, 12, 111, 129);
    // Collected on the third live frame.
    push(K_DESP, 15, 700, 600);
    Reset = 1'b0;

    wait_edge(12); was_collected = 1'b1;   // first live frame: masked
    wait_edge(13); was_collected = 1'b0;
    wait_edge(14); was_collected = 1'b1;   // held through WAIT/PLACE as a stale latch

    // Draws at 20,21 rejected, 22 accepted (15E0 -> cx 480, cy 87); a stuck reject count would fold at 20.
    push(K_SPAWN, 22, 512, 119);
    push(K_DESP, 32, 700, 600);
    wait_edge(23); was_collected = 1'b0;

    predict(37, ec, x, y);
    push(K_SPAWN, ec, x, y);
    push(K_DESP, ec + 10, 700, 600);
    wait_edge(ec);
    enable = 1'b0;
    repeat (20) @(negedge frame_clk);
    enable = 1'b1;

    predict(ec + 15, ed, x, y);
    push(K_SPAWN, ed, x, y);
    push(K_DESP, 0, 700, 600);
    wait_edge(ed + 3);
    Reset = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;

    push(K_SPAWN, 12, 111, 129);
    wait_edge(14);
    @(negedge frame_clk);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
